boss_ctrl: RTL
==============

// Module: boss_ctrl
// PURPOSE
//  Sequences the stage-3 boss: position, sprite frame index, hit points, attack trigger.
//  Drives boss_x/boss_y/boss_state of the boss sprite renderer (10x10 frames, 320x240 space).
//  Outside STAGE3 it only cycles idle frames for the TITLE/FAIL/STAFF screen cameos.
//  Sits between the game FSM, the collision unit (hit) and the bullet generator (fire).
// PARAMETERS
//  ANIM_DIV      4    ticks per animation frame step
//  ATTACK_PERIOD 120  ticks in MOVE between attacks
//  HURT_TICKS    16   ticks of hurt/invulnerable display
//  HP_INIT       8    hit points at stage entry (1..15)
//  X_MIN         20   left patrol bound (boss_x)
//  X_MAX         290  right patrol bound; X_MAX <= 310
//  Y_INIT        40   fixed boss_y
//  X_INIT        150  boss_x at reset/stage entry
//  STEP          1    pixels moved per tick
// PORTS
//  clk        in  1  system clock
//  rst        in  1  asynchronous, active-high reset
//  state      in  4  game state code (STAGE3=6, TITLE=0, STAFF=1, FAIL=8)
//  tick       in  1  one-clk pulse per video frame (vsync)
//  hit        in  1  one-clk pulse: player bullet hit boss
//  boss_x     out 9  sprite left x
//  boss_y     out 9  sprite top y
//  boss_state out 4  sprite frame index 0..9
//  boss_hp    out 4  remaining hit points
//  boss_dead  out 1  level: death sequence finished
//  fire       out 1  one-clk pulse: spawn boss bullet
// BEHAVIOUR
//  Reset (async): FSM=IDLE, boss_x=X_INIT, boss_y=Y_INIT, boss_state=0, boss_hp=HP_INIT,
//   boss_dead=0, fire=0, dir=right, all counters 0.
//  Frames: 0-3 idle/move loop, 4-5 attack, 6 hurt, 7-9 death.
//  anim counter counts ticks 0..ANIM_DIV-1; frame steps on wrap (tick with count=ANIM_DIV-1).
//  FSM (registered, all updates on clk rising edge):
//   IDLE: state!=STAGE3. Frames loop 0..3. Position/hp held at init values.
//         state==STAGE3 -> MOVE next cycle; counters cleared, boss_state=0.
//   MOVE: on tick boss_x +/- STEP by dir; if result passes bound, clamp to bound
//         and flip dir (never leaves [X_MIN,X_MAX]). Frames loop 0..3.
//         attack counter ++ per tick; reaching ATTACK_PERIOD -> ATTACK, counter=0,
//         fire=1 for exactly that transition cycle.
//   ATTACK: frame 4 then 5 (one anim step each), no movement, then -> MOVE, frame 0.
//   HURT: frame 6, no movement, hit ignored; after HURT_TICKS ticks -> MOVE.
//   DEAD: frames 7,8,9 one anim step each, then hold 9; boss_dead=1 from hold onward.
//         hit ignored; fire never asserted.
//  hit (sampled every clk, MOVE/ATTACK only): hp>1 -> hp-1, HURT; hp==1 -> hp=0, DEAD.
//  Priority same cycle: leaving STAGE3 > hit > attack expiry > anim/move. Hit during
//   ATTACK aborts attack (no second fire).
//  Leaving STAGE3 from any state -> IDLE next cycle, re-init all outputs as at reset.
//  tick and hit coincident: hit processed, movement for that tick skipped.
//  boss_state never exceeds 9; counters saturate/wrap only within their ranges.
// STRUCTURE
//  Shared package/header: game state codes (TITLE..HELP), boss frame index constants,
//   320x240 screen limits. Used also by game FSM and sprite renderers.
//  Sub-module: boss_anim_tick (tick -> anim-step pulse divider, clear input).
//  FSM, position, hp, fire in boss_ctrl itself.
// TESTING
//  rst pulse mid-MOVE (boss_x=200) -> outputs immediately X_INIT=150, Y_INIT=40, hp=8, frame 0.
//  state=6, 140 ticks from X_INIT, dir right -> boss_x reaches 290, next tick 289 (dir flipped).
//  120 ticks in MOVE -> fire high exactly 1 clk, frames 4,5 at 4-tick steps, no x change.
//  8 hits spaced >16 ticks -> hp 7..1 with HURT each; 8th -> DEAD, frames 7,8,9, boss_dead=1.
//  hit during HURT and hit coincident with attack expiry -> hp unchanged / HURT wins, fire=0.
//  state 6->8 in HURT -> IDLE next clk, hp=8, x=150, frames loop 0..3 on ticks.

Source files
------------

// File: rtl/boss_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// boss_ctrl_pkg
// Shared definitions for the stage-3 boss controller and its neighbours
// (game FSM, sprite renderers): game state codes, screen limits, boss sprite
// frame indices and the boss sequencer state type.
// ----------------------------------------------------------------------------
package boss_ctrl_pkg;

    // Game state codes driven by the game FSM
    localparam logic [3:0] GS_TITLE  = 4'd0;
    localparam logic [3:0] GS_STAFF  = 4'd1;
    localparam logic [3:0] GS_STAGE3 = 4'd6;
    localparam logic [3:0] GS_FAIL   = 4'd8;

    // Playfield and sprite geometry
    localparam int SCREEN_W      = 320;
    localparam int SCREEN_H      = 240;
    localparam int BOSS_SPRITE_W = 10;
    localparam int BOSS_SPRITE_H = 10;

    // Boss sprite frame indices
    localparam logic [3:0] FR_LOOP_FIRST = 4'd0;
    localparam logic [3:0] FR_LOOP_LAST  = 4'd3;
    localparam logic [3:0] FR_ATTACK_A   = 4'd4;
    localparam logic [3:0] FR_ATTACK_B   = 4'd5;
    localparam logic [3:0] FR_HURT       = 4'd6;
    localparam logic [3:0] FR_DEAD_FIRST = 4'd7;
    localparam logic [3:0] FR_DEAD_LAST  = 4'd9;

    // Boss sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MOVE   = 3'd1,
        ST_ATTACK = 3'd2,
        ST_HURT   = 3'd3,
        ST_DEAD   = 3'd4
    } boss_fsm_t;

    // Next frame of the idle/move loop 0..3
    function automatic logic [3:0] loop_frame_next(input logic [3:0] f);
        if (f >= FR_LOOP_LAST) begin
            return FR_LOOP_FIRST;
        end else begin
            return f + 4'd1;
        end
    endfunction

endpackage

// File: rtl/boss_ctrl_anim_tick.sv
// ----------------------------------------------------------------------------
// boss_anim_tick
// Divides the per-frame tick down to animation steps: counts ticks
// 0..ANIM_DIV-1 and flags a step on the tick that wraps the count.
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   tick_i  in   one-clk pulse per video frame
//   clr_i   in   synchronous clear of the tick count (wins over tick_i)
//   step_o  out  animation step (tick_i while count == ANIM_DIV-1)
// ----------------------------------------------------------------------------
module boss_anim_tick #(
    parameter int ANIM_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic clr_i,
    output logic step_o
);

    localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ANIM_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Step is independent of clr_i so the owner may use it to decide clr_i
    assign step_o = tick_i && (cnt_q == CNT_LAST);

    // Tick count next-state: clear, wrap on last, else increment per tick
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Tick count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/boss_ctrl.sv
// ----------------------------------------------------------------------------
// boss_ctrl
// Sequences the stage-3 boss: patrol position, sprite frame, hit points,
// attack trigger. Outside STAGE3 it only loops the idle frames for cameos.
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   state_i[3:0]  in   game state code (STAGE3 = 6)
//   tick_i        in   one-clk pulse per video frame
//   hit_i         in   one-clk pulse: player bullet hit the boss
//   boss_x_o[8:0] out  sprite left x
//   boss_y_o[8:0] out  sprite top y (fixed)
//   boss_state_o  out  sprite frame index 0..9
//   boss_hp_o     out  remaining hit points
//   boss_dead_o   out  death sequence finished (level)
//   fire_o        out  one-clk pulse: spawn a boss bullet
// ----------------------------------------------------------------------------
module boss_ctrl
    import boss_ctrl_pkg::*;
#(
    parameter int ANIM_DIV      = 4,
    parameter int ATTACK_PERIOD = 120,
    parameter int HURT_TICKS    = 16,
    parameter int HP_INIT       = 8,
    parameter int X_MIN         = 20,
    parameter int X_MAX         = 290,
    parameter int Y_INIT        = 40,
    parameter int X_INIT        = 150,
    parameter int STEP          = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state_i,
    input  logic       tick_i,
    input  logic       hit_i,
    output logic [8:0] boss_x_o,
    output logic [8:0] boss_y_o,
    output logic [3:0] boss_state_o,
    output logic [3:0] boss_hp_o,
    output logic       boss_dead_o,
    output logic       fire_o
);

    localparam int ATK_W  = $clog2(ATTACK_PERIOD + 1);
    localparam int HURT_W = $clog2(HURT_TICKS + 1);

    localparam logic [ATK_W-1:0]  ATK_LAST  = ATK_W'(ATTACK_PERIOD - 1);
    localparam logic [HURT_W-1:0] HURT_LAST = HURT_W'(HURT_TICKS - 1);
    localparam logic [8:0]        X_INIT_V  = 9'(X_INIT);
    localparam logic [8:0]        X_MIN_V   = 9'(X_MIN);
    localparam logic [8:0]        X_MAX_V   = 9'(X_MAX);
    localparam logic [8:0]        STEP_V    = 9'(STEP);
    // Thresholds at which one more step would reach or pass a bound
    localparam logic [8:0]        X_RIGHT_TURN = 9'(X_MAX - STEP);
    localparam logic [8:0]        X_LEFT_TURN  = 9'(X_MIN + STEP);
    localparam logic [3:0]        HP_INIT_V = 4'(HP_INIT);

    boss_fsm_t         fsm_q, fsm_d;
    logic [8:0]        x_q, x_d;
    logic              dir_right_q, dir_right_d;
    logic [3:0]        frame_q, frame_d;
    logic [3:0]        hp_q, hp_d;
    logic              dead_q, dead_d;
    logic              fire_q, fire_d;
    logic [ATK_W-1:0]  atk_q, atk_d;
    logic [HURT_W-1:0] hurt_q, hurt_d;

    logic in_stage3_s;
    logic hit_taken_s;
    logic anim_step_s;
    logic anim_clr_s;

    assign in_stage3_s = (state_i == GS_STAGE3);
    // Hits only land while the boss is vulnerable
    assign hit_taken_s = hit_i && ((fsm_q == ST_MOVE) || (fsm_q == ST_ATTACK));

    boss_anim_tick #(
        .ANIM_DIV (ANIM_DIV)
    ) u_anim (
        .clk    (clk),
        .rst    (rst),
        .tick_i (tick_i),
        .clr_i  (anim_clr_s),
        .step_o (anim_step_s)
    );

    // Sequencer next-state: stage exit > hit > attack expiry > anim/move
    always_comb begin
        fsm_d       = fsm_q;
        x_d         = x_q;
        dir_right_d = dir_right_q;
        frame_d     = frame_q;
        hp_d        = hp_q;
        dead_d      = dead_q;
        fire_d      = 1'b0;
        atk_d       = atk_q;
        hurt_d      = hurt_q;
        anim_clr_s  = 1'b0;

        if (!in_stage3_s) begin
            if (fsm_q != ST_IDLE) begin
                fsm_d       = ST_IDLE;
                x_d         = X_INIT_V;
                dir_right_d = 1'b1;
                frame_d     = FR_LOOP_FIRST;
                hp_d        = HP_INIT_V;
                dead_d      = 1'b0;
                atk_d       = '0;
                hurt_d      = '0;
                anim_clr_s  = 1'b1;
            end else if (anim_step_s) begin
                frame_d = loop_frame_next(frame_q);
            end else begin
                frame_d = frame_q;
            end
        end else if (hit_taken_s) begin
            anim_clr_s = 1'b1;
            if (hp_q > 4'd1) begin
                hp_d    = hp_q - 4'd1;
                fsm_d   = ST_HURT;
                frame_d = FR_HURT;
                hurt_d  = '0;
            end else begin
                hp_d    = 4'd0;
                fsm_d   = ST_DEAD;
                frame_d = FR_DEAD_FIRST;
            end
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    fsm_d       = ST_MOVE;
                    x_d         = X_INIT_V;
                    dir_right_d = 1'b1;
                    frame_d     = FR_LOOP_FIRST;
                    hp_d        = HP_INIT_V;
                    dead_d      = 1'b0;
                    atk_d       = '0;
                    hurt_d      = '0;
                    anim_clr_s  = 1'b1;
                end
                ST_MOVE: begin
                    if (tick_i) begin
                        if (atk_q == ATK_LAST) begin
                            // Attack expiry pre-empts this tick's movement
                            fsm_d      = ST_ATTACK;
                            atk_d      = '0;
                            fire_d     = 1'b1;
                            frame_d    = FR_ATTACK_A;
                            anim_clr_s = 1'b1;
                        end else begin
                            atk_d = atk_q + ATK_W'(1);
                            if (dir_right_q) begin
                                if (x_q >= X_RIGHT_TURN) begin
                                    x_d         = X_MAX_V;
                                    dir_right_d = 1'b0;
                                end else begin
                                    x_d = x_q + STEP_V;
                                end
                            end else begin
                                if (x_q <= X_LEFT_TURN) begin
                                    x_d         = X_MIN_V;
                                    dir_right_d = 1'b1;
                                end else begin
                                    x_d = x_q - STEP_V;
                                end
                            end
                            if (anim_step_s) begin
                                frame_d = loop_frame_next(frame_q);
                            end else begin
                                frame_d = frame_q;
                            end
                        end
                    end else begin
                        atk_d = atk_q;
                    end
                end
                ST_ATTACK: begin
                    if (anim_step_s) begin
                        if (frame_q == FR_ATTACK_A) begin
                            frame_d = FR_ATTACK_B;
                        end else begin
                            fsm_d      = ST_MOVE;
                            frame_d    = FR_LOOP_FIRST;
                            anim_clr_s = 1'b1;
                        end
                    end else begin
                        frame_d = frame_q;
                    end
                end
                ST_HURT: begin
                    if (tick_i) begin
                        if (hurt_q == HURT_LAST) begin
                            fsm_d      = ST_MOVE;
                            frame_d    = FR_LOOP_FIRST;
                            hurt_d     = '0;
                            anim_clr_s = 1'b1;
                        end else begin
                            hurt_d = hurt_q + HURT_W'(1);
                        end
                    end else begin
                        hurt_d = hurt_q;
                    end
                end
                ST_DEAD: begin
                    // Frame 9 is shown for one full step before the dead flag
                    if (anim_step_s) begin
                        if (frame_q < FR_DEAD_LAST) begin
                            frame_d = frame_q + 4'd1;
                        end else begin
                            dead_d = 1'b1;
                        end
                    end else begin
                        frame_d = frame_q;
                    end
                end
                default: begin
                    fsm_d       = ST_IDLE;
                    x_d         = X_INIT_V;
                    dir_right_d = 1'b1;
                    frame_d     = FR_LOOP_FIRST;
                    hp_d        = HP_INIT_V;
                    dead_d      = 1'b0;
                    atk_d       = '0;
                    hurt_d      = '0;
                    anim_clr_s  = 1'b1;
                end
            endcase
        end
    end

    // Sequencer and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            x_q         <= X_INIT_V;
            dir_right_q <= 1'b1;
            frame_q     <= FR_LOOP_FIRST;
            hp_q        <= HP_INIT_V;
            dead_q      <= 1'b0;
            fire_q      <= 1'b0;
            atk_q       <= '0;
            hurt_q      <= '0;
        end else begin
            fsm_q       <= fsm_d;
            x_q         <= x_d;
            dir_right_q <= dir_right_d;
            frame_q     <= frame_d;
            hp_q        <= hp_d;
            dead_q      <= dead_d;
            fire_q      <= fire_d;
            atk_q       <= atk_d;
            hurt_q      <= hurt_d;
        end
    end

    assign boss_x_o     = x_q;
    assign boss_y_o     = 9'(Y_INIT);
    assign boss_state_o = frame_q;
    assign boss_hp_o    = hp_q;
    assign boss_dead_o  = dead_q;
    assign fire_o       = fire_q;

endmodule
